// File: rtl/mc_rf_serial.sv
// mc_rf_serial: bit-serial two-read/two-write register file with independent read and write stream engines
module mc_rf_serial #(
  parameter int AW = 6,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_rreq,
  input  logic          i_wreq,
  input  logic [AW-1:0] i_rreg0,
  input  logic [AW-1:0] i_rreg1,
  input  logic [AW-1:0] i_wreg0,
  input  logic [AW-1:0] i_wreg1,
  input  logic          i_wen0,
  input  logic          i_wen1,
  input  logic          i_wdata0,
  input  logic          i_wdata1,
  output logic          o_ready,
  output logic          o_rdata0,
  output logic          o_rdata1,
  output logic          o_err
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  // LEAD is the o_ready cycle after an accept; STREAM covers the W bit cycles
  localparam logic [1:0] IDLE = 2'd0, LEAD = 2'd1, STREAM = 2'd2;

  logic [W-1:0]  mem [2**AW];
  logic [1:0]    rstate, wstate;
  logic [CW-1:0] rcnt, wcnt, ridx;
  logic [AW-1:0] ra0, ra1, wa0, wa1;
  logic          racc, wacc, rnext;

  assign racc  = i_rreq & (rstate == IDLE);
  assign wacc  = i_wreq & (wstate == IDLE);
  assign rnext = (rstate == LEAD) | ((rstate == STREAM) & (rcnt != LAST));
  assign ridx  = (rstate == LEAD) ? '0 : rcnt + 1'b1;

  // Read engine: outputs are loaded one edge ahead so bit i appears in the cycle its counter equals i
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      rstate   <= IDLE;
      rcnt     <= '0;
      o_rdata0 <= 1'b0;
      o_rdata1 <= 1'b0;
    end else begin
      rstate   <= (rstate == IDLE) ? (racc ? LEAD : IDLE) :
                  (rstate == LEAD) ? STREAM : ((rcnt == LAST) ? IDLE : STREAM);
      rcnt     <= ((rstate == STREAM) && (rcnt != LAST)) ? rcnt + 1'b1 : '0;
      ra0      <= racc ? i_rreg0 : ra0;
      ra1      <= racc ? i_rreg1 : ra1;
      o_rdata0 <= rnext && (ra0 != '0) && mem[ra0][ridx];
      o_rdata1 <= rnext && (ra1 != '0) && mem[ra1][ridx];
    end
  end

  // Write engine control: counter tracks the bit being written during STREAM
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      wstate <= IDLE;
      wcnt   <= '0;
    end else begin
      wstate <= (wstate == IDLE) ? (wacc ? LEAD : IDLE) :
                (wstate == LEAD) ? STREAM : ((wcnt == LAST) ? IDLE : STREAM);
      wcnt   <= ((wstate == STREAM) && (wcnt != LAST)) ? wcnt + 1'b1 : '0;
      wa0    <= wacc ? i_wreg0 : wa0;
      wa1    <= wacc ? i_wreg1 : wa1;
    end
  end

  // Storage: unreset flops; port 1 is assigned last so it wins on a same-bit collision
  always_ff @(posedge clk) begin
    if (i_rst_n && (wstate == STREAM)) begin
      if (i_wen0 && (wa0 != '0)) mem[wa0][wcnt] <= i_wdata0;
      if (i_wen1 && (wa1 != '0)) mem[wa1][wcnt] <= i_wdata1;
    end
  end

  // Status: one ready pulse per accept cycle, sticky error on a request to a busy engine
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      o_ready <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_ready <= racc | wacc;
      o_err   <= o_err | (i_rreq & (rstate != IDLE)) | (i_wreq & (wstate != IDLE));
    end
  end
endmodule

// File: tb/tb_mc_rf_serial.sv
// tb_mc_rf_serial: directed scoreboard bench for the serial register file
module tb_mc_rf_serial;
  localparam int AW = 6, W = 32;
  logic clk = 0, rst_n = 0, rreq = 0, wreq = 0;
  logic [AW-1:0] rreg0 = 0, rreg1 = 0, wreg0 = 0, wreg1 = 0;
  logic wen0 = 0, wen1 = 0, wdata0 = 0, wdata1 = 0;
  logic o_ready, o_rdata0, o_rdata1, o_err;

  mc_rf_serial #(.AW(AW), .W(W)) dut (
    .clk(clk), .i_rst_n(rst_n), .i_rreq(rreq), .i_wreq(wreq),
    .i_rreg0(rreg0), .i_rreg1(rreg1), .i_wreg0(wreg0), .i_wreg1(wreg1),
    .i_wen0(wen0), .i_wen1(wen1), .i_wdata0(wdata0), .i_wdata1(wdata1),
    .o_ready(o_ready), .o_rdata0(o_rdata0), .o_rdata1(o_rdata1), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  logic [W-1:0] model [2**AW];

  typedef struct {
    bit rd;
    int t;
    logic [W-1:0] e0;
    logic [W-1:0] e1;
  } exp_t;
  exp_t q[$];
  exp_t me;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expectation on each o_ready, then collects W read bits
  int ncol = 0;
  logic [W-1:0] c0, c1, x0, x1;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ncol > 0) begin
        c0[W-ncol] = o_rdata0;
        c1[W-ncol] = o_rdata1;
        ncol--;
        if (ncol == 0) begin
          chk("rdata0", c0, x0);
          chk("rdata1", c1, x1);
        end
      end else chk("rdata_idle", {30'b0, o_rdata1, o_rdata0}, 32'd0);
      if (o_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL ready: unexpected o_ready at cycle %0d", cyc);
        end else begin
          me = q.pop_front();
          chk("ready_time", cyc, me.t + 1);
          if (me.rd) begin
            ncol = W;
            x0 = me.e0;
            x1 = me.e1;
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] mval(int a);
    return (a == 0) ? '0 : model[a];
  endfunction

  task automatic req(bit rd, bit wr, int r0, int r1, int w0, int w1);
    rreq = rd; wreq = wr;
    rreg0 = AW'(r0); rreg1 = AW'(r1); wreg0 = AW'(w0); wreg1 = AW'(w1);
    q.push_back('{rd, cyc, mval(r0), mval(r1)});
    tick(1);
    rreq = 0; wreq = 0;
  endtask

  task automatic wstream(int a0, int a1, logic [W-1:0] d0, logic [W-1:0] d1, bit e0, bit e1);
    for (int i = 0; i < W; i++) begin
      tick(1);
      wen0 = e0; wen1 = e1; wdata0 = d0[i]; wdata1 = d1[i];
    end
    tick(1);
    wen0 = 0; wen1 = 0; wdata0 = 0; wdata1 = 0;
    if (e0 && a0 != 0) model[a0] = d0;
    if (e1 && a1 != 0) model[a1] = d1;
  endtask

  task automatic wr(int a0, int a1, logic [W-1:0] d0, logic [W-1:0] d1, bit e0, bit e1);
    tick(1);
    req(0, 1, 0, 0, a0, a1);
    wstream(a0, a1, d0, d1, e0, e1);
  endtask

  task automatic rd(int a0, int a1);
    tick(1);
    req(1, 0, a0, a1, 0, 0);
    tick(W + 1);
  endtask

  int t0;
  initial begin
    tick(3);
    @(negedge clk);
    chk("rst_ready", o_ready, 0);
    chk("rst_err", o_err, 0);
    chk("rst_rdata", {o_rdata1, o_rdata0}, 0);
    tick(1);
    rst_n = 1;
    wr(5, 0, 32'hDEADBEEF, 0, 1, 0);
    rd(5, 0);
    wen0 = 1; wen1 = 1; wdata0 = 1; wdata1 = 1;
    rd(5, 5);
    wen0 = 0; wen1 = 0; wdata0 = 0; wdata1 = 0;
    rd(5, 0);
    wr(0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
    rd(0, 0);
    @(negedge clk);
    chk("err_after_x0", o_err, 0);
    wr(33, 33, 32'h00000000, 32'h12345678, 1, 1);
    rd(33, 5);
    wr(7, 9, 0, 0, 1, 1);
    tick(1);
    t0 = cyc;
    req(1, 0, 33, 5, 0, 0);
    tick(9);
    rreq = 1; rreg0 = 7; rreg1 = 9;
    tick(1);
    rreq = 0;
    @(negedge clk);
    chk("busy_no_ready", o_ready, 0);
    chk("busy_err", o_err, 1);
    tick(t0 + 34 - cyc);
    req(1, 0, 5, 33, 0, 0);
    @(negedge clk);
    chk("accept_ready", o_ready, 1);
    chk("err_sticky", o_err, 1);
    tick(W + 1);
    tick(1);
    req(1, 1, 7, 7, 7, 0);
    wstream(7, 0, 32'hA5A5A5A5, 0, 1, 0);
    rd(7, 9);
    tick(1);
    req(0, 1, 0, 0, 9, 0);
    for (int i = 0; i < 8; i++) begin
      tick(1);
      wen0 = 1; wdata0 = 1;
    end
    tick(1);
    rst_n = 0;
    @(negedge clk);
    chk("err_before_rst", o_err, 1);
    tick(1);
    rst_n = 1; wen0 = 0; wdata0 = 0;
    @(negedge clk);
    chk("midrst_ready", o_ready, 0);
    chk("midrst_err", o_err, 0);
    chk("midrst_rdata", {o_rdata1, o_rdata0}, 0);
    model[9] = 32'h000000FF;
    rd(9, 7);
    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got cycle %0d want completion", cyc);
    $fatal(1, "timeout");
  end
endmodule
